// File: rtl/thread_sched_pkg.sv
// Shared constants, FSM state encoding and a one-hot helper for the thread scheduler.
package thread_sched_pkg;

  localparam int NUM_THREADS = 8;
  localparam int THR_W       = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SWITCH = 2'd1,
    ST_IDLE   = 2'd2
  } sched_state_t;

  function automatic logic [NUM_THREADS-1:0] thr_bit(input logic [THR_W-1:0] id);
    logic [NUM_THREADS-1:0] b;
    b = '0;
    b[id] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/thread_sched_rr_pick.sv
// Rotate-priority encoder: first set bit of mask searching upward from base, wrapping to 0.
module thr_rr_pick
  import thread_sched_pkg::*;
(
  input  logic [NUM_THREADS-1:0] mask,
  input  logic [THR_W-1:0]       base,
  output logic [THR_W-1:0]       id,
  output logic                   found
);

  logic [THR_W-1:0] idx;

  always_comb begin
    id    = base;
    found = 1'b0;
    idx   = base;
    for (int i = 0; i < NUM_THREADS; i++) begin
      // THR_W-bit addition wraps naturally because NUM_THREADS is a power of 2
      idx = base + THR_W'(i);
      if (!found && mask[idx]) begin
        id    = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_sched.sv
// Round-robin hardware thread selector with start/stop/halt/irq run-mask control.
// Optional time-slice mode is enabled by defining THREAD_QUANTUM_EN.
module thread_sched
  import thread_sched_pkg::*;
#(
  parameter logic [NUM_THREADS-1:0] RESET_MASK = 8'h01,
  parameter int                     QUANTUM    = 16
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   RDY,
  input  logic                   sync,
  input  logic                   thr_start,
  input  logic                   thr_stop,
  input  logic [THR_W-1:0]       thr_id,
  input  logic                   halt_self,
  input  logic [NUM_THREADS-1:0] irq,
  output logic [THR_W-1:0]       reg_thr,
  output logic [NUM_THREADS-1:0] run_mask,
  output logic                   thr_switch,
  output logic                   idle,
  output logic [1:0]             dbg_state
);

  sched_state_t           state;
  logic [NUM_THREADS-1:0] start_bit, stop_bit, halt_bit, next_mask;
  logic [THR_W-1:0]       pick_base, pick_id;
  logic                   pick_found;
  logic                   eval, do_sync, take_switch, go_idle, wake;

  assign start_bit = thr_start ? thr_bit(thr_id)  : '0;
  assign stop_bit  = thr_stop  ? thr_bit(thr_id)  : '0;
  assign halt_bit  = halt_self ? thr_bit(reg_thr) : '0;
  // Clears are applied last so stop/halt beat start and irq on the same thread
  assign next_mask = (run_mask | irq | start_bit) & ~stop_bit & ~halt_bit;

  assign pick_base = reg_thr + THR_W'(1);

  thr_rr_pick u_pick (
    .mask  (next_mask),
    .base  (pick_base),
    .id    (pick_id),
    .found (pick_found)
  );

  assign do_sync     = RDY && sync && (state == ST_RUN);
  assign take_switch = do_sync && eval && pick_found && (pick_id != reg_thr);
  assign go_idle     = do_sync && eval && !pick_found;
  assign wake        = RDY && (state == ST_IDLE) && pick_found;

`ifdef THREAD_QUANTUM_EN
  localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  logic [CNT_W-1:0] q_cnt;

  // Re-evaluate at slice end, or early if the running thread lost its run bit
  assign eval = (q_cnt == CNT_W'(QUANTUM - 1)) || !next_mask[reg_thr];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      q_cnt <= '0;
    end else if (take_switch || go_idle || wake) begin
      q_cnt <= '0;
    end else if (do_sync) begin
      q_cnt <= q_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (QUANTUM != 0);
  assign eval       = 1'b1;
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      run_mask   <= RESET_MASK;
      reg_thr    <= '0;
      thr_switch <= 1'b0;
      idle       <= (RESET_MASK == '0);
      state      <= (RESET_MASK == '0) ? ST_IDLE : ST_RUN;
    end else begin
      run_mask   <= next_mask;
      thr_switch <= 1'b0;
      if (RDY) begin
        case (state)
          ST_RUN: begin
            if (go_idle) begin
              idle  <= 1'b1;
              state <= ST_IDLE;
            end else if (take_switch) begin
              reg_thr    <= pick_id;
              thr_switch <= 1'b1;
              state      <= ST_SWITCH;
            end
          end
          ST_SWITCH: state <= ST_RUN;
          ST_IDLE: begin
            if (pick_found) begin
              idle <= 1'b0;
              if (pick_id != reg_thr) begin
                reg_thr    <= pick_id;
                thr_switch <= 1'b1;
                state      <= ST_SWITCH;
              end else begin
                state <= ST_RUN;
              end
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_thread_sched.sv
// Self-checking bench for thread_sched: directed scenarios plus randomized run against a reference model.
`timescale 1ns/1ps
module tb_thread_sched;

  localparam int N = 8;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       RDY = 1'b1;
  logic       sync = 1'b0;
  logic       thr_start = 1'b0;
  logic       thr_stop = 1'b0;
  logic [2:0] thr_id = '0;
  logic       halt_self = 1'b0;
  logic [7:0] irq = '0;
  logic [2:0] reg_thr;
  logic [7:0] run_mask;
  logic       thr_switch;
  logic       idle;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;

  // Reference model: run set, current thread, idle flag, post-switch bubble, slice count
  logic [7:0] m_mask;
  int         m_cur;
  bit         m_idle, m_bubble, m_sw;
  int         m_cnt;

  thread_sched #(.RESET_MASK(8'h01), .QUANTUM(Q)) dut (
    .clk(clk), .RST(RST), .RDY(RDY), .sync(sync), .thr_start(thr_start),
    .thr_stop(thr_stop), .thr_id(thr_id), .halt_self(halt_self), .irq(irq),
    .reg_thr(reg_thr), .run_mask(run_mask), .thr_switch(thr_switch),
    .idle(idle), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int next_runnable(input logic [7:0] m, input int cur);
    for (int k = 1; k <= N; k++) begin
      if (m[(cur + k) % N]) return (cur + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mask = 8'h01; m_cur = 0; m_idle = 0; m_bubble = 0; m_sw = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [7:0] nm;
    int nxt;
    bit ev;
    nm = m_mask | irq;
    if (thr_start) nm[thr_id] = 1'b1;
    if (thr_stop) nm[thr_id] = 1'b0;
    if (halt_self) nm[m_cur] = 1'b0;
    m_sw = 0;
    if (RDY) begin
      if (m_bubble) begin
        m_bubble = 0;
      end else if (m_idle) begin
        if (nm != 0) begin
          m_idle = 0; m_cnt = 0;
          nxt = next_runnable(nm, m_cur);
          if (nxt != m_cur) begin m_cur = nxt; m_sw = 1; m_bubble = 1; end
        end
      end else if (sync) begin
`ifdef THREAD_QUANTUM_EN
        ev = (m_cnt == Q - 1) || !nm[m_cur];
`else
        ev = 1;
`endif
        if (!ev) m_cnt = m_cnt + 1;
        else if (nm == 0) begin m_idle = 1; m_cnt = 0; end
        else begin
          nxt = next_runnable(nm, m_cur);
          if (nxt != m_cur) begin m_cur = nxt; m_sw = 1; m_bubble = 1; m_cnt = 0; end
          else m_cnt = (m_cnt + 1) % Q;
        end
      end
    end
    m_mask = nm;
  endtask

  task automatic cycle(input bit s, input bit st, input bit sp, input int id,
                       input bit hs, input logic [7:0] ir, input bit rdy);
    sync = s; thr_start = st; thr_stop = sp; thr_id = 3'(id);
    halt_self = hs; irq = ir; RDY = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 8'h00, 1);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    sync = 0; thr_start = 0; thr_stop = 0; thr_id = 0; halt_self = 0; irq = 0; RDY = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (reg_thr !== 3'd0) begin bad++; $display("FAIL reset_reg_thr got=%0d exp=0", reg_thr); end
    total++; if (run_mask !== 8'h01) begin bad++; $display("FAIL reset_run_mask got=%h exp=01", run_mask); end
    total++; if (thr_switch !== 1'b0 || idle !== 1'b0) begin
      bad++; $display("FAIL reset_flags got sw=%b idle=%b exp sw=0 idle=0", thr_switch, idle); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    for (int i = 0; i < 16; i++) begin
      cycle((i % 4) == 0, 0, 0, 0, 0, 8'h00, 1);
      total++;
      if (reg_thr !== 3'd0 || thr_switch !== 1'b0 || idle !== 1'b0) begin
        bad++; $display("FAIL single_thread cyc=%0d got thr=%0d sw=%b idle=%b exp 0/0/0", i, reg_thr, thr_switch, idle);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[4] = '{3, 5, 0, 3};
    cycle(0, 1, 0, 3, 0, 8'h00, 1);
    cycle(0, 1, 0, 5, 0, 8'h00, 1);
    total++; if (run_mask !== 8'h29) begin bad++; $display("FAIL rr_mask got=%h exp=29", run_mask); end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0, 8'h00, 1);
      total++;
      if (reg_thr !== 3'(exp_seq[i]) || thr_switch !== 1'b1) begin
        bad++; $display("FAIL rr_step%0d got thr=%0d sw=%b exp thr=%0d sw=1", i, reg_thr, thr_switch, exp_seq[i]);
      end
      cycle(0, 0, 0, 0, 0, 8'h00, 1);
      total++; if (thr_switch !== 1'b0) begin bad++; $display("FAIL rr_pulse%0d got sw=%b exp=0", i, thr_switch); end
      idle_cycles(2);
    end
  endtask

  task automatic test_wrap_idle();
    cycle(0, 0, 1, 0, 0, 8'h00, 1);
    total++; if (run_mask !== 8'h28) begin bad++; $display("FAIL wrap_mask got=%h exp=28", run_mask); end
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    total++; if (reg_thr !== 3'd5) begin bad++; $display("FAIL wrap_to5 got=%0d exp=5", reg_thr); end
    idle_cycles(3);
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    total++; if (reg_thr !== 3'd3 || thr_switch !== 1'b1) begin
      bad++; $display("FAIL wrap_to3 got thr=%0d sw=%b exp thr=3 sw=1", reg_thr, thr_switch); end
    idle_cycles(3);
    cycle(0, 0, 1, 3, 0, 8'h00, 1);
    idle_cycles(1);
    total++; if (reg_thr !== 3'd3 || run_mask !== 8'h20) begin
      bad++; $display("FAIL stop_no_sync got thr=%0d mask=%h exp thr=3 mask=20", reg_thr, run_mask); end
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    idle_cycles(3);
    cycle(0, 0, 0, 0, 1, 8'h00, 1);
    total++; if (run_mask !== 8'h00 || reg_thr !== 3'd5 || idle !== 1'b0) begin
      bad++; $display("FAIL halt_self got mask=%h thr=%0d idle=%b exp 00/5/0", run_mask, reg_thr, idle); end
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    total++; if (idle !== 1'b1 || reg_thr !== 3'd5 || thr_switch !== 1'b0) begin
      bad++; $display("FAIL go_idle got idle=%b thr=%0d sw=%b exp 1/5/0", idle, reg_thr, thr_switch); end
    idle_cycles(2);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL stay_idle got=%b exp=1", idle); end
    cycle(0, 0, 0, 0, 0, 8'h04, 1);
    total++; if (idle !== 1'b0 || reg_thr !== 3'd2 || thr_switch !== 1'b1) begin
      bad++; $display("FAIL irq_wake got idle=%b thr=%0d sw=%b exp 0/2/1", idle, reg_thr, thr_switch); end
    idle_cycles(2);
  endtask

  task automatic test_conflict();
    cycle(0, 1, 1, 6, 0, 8'h00, 1);
    total++; if (run_mask[6] !== 1'b0) begin bad++; $display("FAIL start_stop got=%b exp=0", run_mask[6]); end
    cycle(0, 0, 1, 6, 0, 8'h40, 1);
    total++; if (run_mask[6] !== 1'b0) begin bad++; $display("FAIL irq_stop got=%b exp=0", run_mask[6]); end
    cycle(0, 0, 0, 0, 0, 8'h40, 1);
    total++; if (run_mask[6] !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", run_mask[6]); end
    cycle(0, 0, 1, 6, 0, 8'h00, 1);
    total++; if (run_mask !== m_mask) begin bad++; $display("FAIL conflict_mask got=%h exp=%h", run_mask, m_mask); end
  endtask

  task automatic test_rdy();
    do_reset();
    cycle(0, 1, 0, 1, 0, 8'h00, 1);
    cycle(0, 0, 1, 0, 0, 8'h00, 1);
    cycle(1, 0, 0, 0, 0, 8'h00, 0);
    total++; if (reg_thr !== 3'd0 || thr_switch !== 1'b0) begin
      bad++; $display("FAIL rdy_freeze got thr=%0d sw=%b exp 0/0", reg_thr, thr_switch); end
    cycle(0, 1, 0, 0, 0, 8'h00, 0);
    total++; if (run_mask !== 8'h03) begin bad++; $display("FAIL rdy_mask got=%h exp=03", run_mask); end
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    total++; if (reg_thr !== 3'd1 || thr_switch !== 1'b1) begin
      bad++; $display("FAIL rdy_resume got thr=%0d sw=%b exp 1/1", reg_thr, thr_switch); end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_switch();
    do_reset();
    cycle(0, 1, 1, 1, 0, 8'h00, 1);
    cycle(0, 1, 0, 1, 0, 8'h00, 1);
    cycle(0, 0, 1, 0, 0, 8'h00, 1);
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    total++; if (reg_thr !== 3'd1 || dbg_state !== 2'd1) begin
      bad++; $display("FAIL pre_reset got thr=%0d st=%0d exp 1/1", reg_thr, dbg_state); end
    #2 RST = 1'b0;
    #1;
    total++; if (reg_thr !== 3'd0 || run_mask !== 8'h01 || thr_switch !== 1'b0 || idle !== 1'b0) begin
      bad++; $display("FAIL async_reset got thr=%0d mask=%h sw=%b idle=%b exp 0/01/0/0",
                      reg_thr, run_mask, thr_switch, idle); end
    model_reset();
    sync = 0; thr_start = 0; thr_stop = 0; halt_self = 0; irq = 0; RDY = 1;
    @(negedge clk);
    RST = 1'b1;
  endtask

  task automatic test_quantum();
    do_reset();
    cycle(0, 1, 0, 1, 0, 8'h00, 1);
    for (int n = 1; n <= 2 * Q; n++) begin
      cycle(1, 0, 0, 0, 0, 8'h00, 1);
      total++;
      if (thr_switch !== ((n % Q) == 0) || reg_thr !== 3'((n / Q) % 2)) begin
        bad++; $display("FAIL quantum_sync%0d got thr=%0d sw=%b exp thr=%0d sw=%b",
                        n, reg_thr, thr_switch, (n / Q) % 2, (n % Q) == 0);
      end
      idle_cycles(2);
    end
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    idle_cycles(2);
    total++; if (reg_thr !== 3'd0) begin bad++; $display("FAIL quantum_pre got=%0d exp=0", reg_thr); end
    cycle(0, 0, 1, 0, 0, 8'h00, 1);
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    total++; if (reg_thr !== 3'd1 || thr_switch !== 1'b1) begin
      bad++; $display("FAIL quantum_stop got thr=%0d sw=%b exp 1/1", reg_thr, thr_switch); end
    idle_cycles(2);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7), $urandom_range(0, 15) == 0,
            ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'h00,
            $urandom_range(0, 5) != 0);
      total++;
      if (reg_thr !== 3'(m_cur) || run_mask !== m_mask || thr_switch !== m_sw || idle !== m_idle) begin
        bad++; $display("FAIL random cyc=%0d got thr=%0d mask=%h sw=%b idle=%b exp thr=%0d mask=%h sw=%b idle=%b",
                        i, reg_thr, run_mask, thr_switch, idle, m_cur, m_mask, m_sw, m_idle);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
`ifndef THREAD_QUANTUM_EN
    test_round_robin();
    test_wrap_idle();
`endif
    test_conflict();
    test_rdy();
    test_reset_mid_switch();
`ifdef THREAD_QUANTUM_EN
    test_quantum();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
